// File: rtl/cdc_xfer_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_xfer_arbiter
//
// Round-robin arbiter that shares one handshake-type CDC channel among
// NUM_REQ requesters in the dst_clk domain. It captures the winner's word,
// issues a single-cycle strobe to the channel source port, follows the
// channel's four-phase ready (drop = strobe registered, rise = transfer done),
// and re-arbitrates only after completion. It also reports completion, a
// sticky in-flight timeout and occupancy.
//
// Optional feature (macro CDC_XFER_ARB_STATS_EN): adds a 32-bit xfer_count
// output counting completed transfers, cleared by reset and by err_clr.
//
// Ports:
//   dst_clk        block clock
//   dst_rst_n      asynchronous active-low reset
//   req_valid      per-requester request level          [NUM_REQ]
//   req_data       packed request words, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      one-hot capture pulse to the winner   [NUM_REQ]
//   cdc_src_data   captured word, held until the next grant
//   cdc_src_valid  single-cycle issue strobe to the channel
//   cdc_src_ready  channel idle indication
//   xfer_done      single-cycle completion pulse
//   grant_id       index of the last granted requester
//   busy           high while a transfer is being issued or in flight
//   err_timeout    sticky: a transfer stayed in flight TIMEOUT_CYCLES cycles
//   err_clr        synchronous clear of err_timeout (a same-cycle set wins)
//   xfer_count     completed-transfer count (only with CDC_XFER_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module cdc_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            dst_clk,
  input  logic                            dst_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           cdc_src_data,
  output logic                            cdc_src_valid,
  input  logic                            cdc_src_ready,
  output logic                            xfer_done,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            err_timeout,
  input  logic                            err_clr
`ifdef CDC_XFER_ARB_STATS_EN
  ,
  output logic [31:0]                     xfer_count
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCEPT   = 2'd1,
    INFLIGHT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        tmo_cnt;

  // Arbitration results for the current cycle.
  logic                    win_found;
  logic [ID_W-1:0]         win_id;
  logic [ID_W-1:0]         win_next_ptr;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [DATA_WIDTH-1:0]   win_data;

  // FSM decisions for the current cycle.
  logic                    grant;
  logic                    done_d;
  logic                    tmo_hit;

  // ---------------------------------------------------------------------------
  // Round-robin winner: first asserted request scanning from rr_ptr upward,
  // wrapping modulo NUM_REQ.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    win_found    = 1'b0;
    win_id       = '0;
    win_next_ptr = '0;
    win_onehot   = '0;
    win_data     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found       = 1'b1;
        win_id          = ID_W'(idx);
        win_next_ptr    = ID_W'((idx + 1) % NUM_REQ);
        win_onehot[idx] = 1'b1;
        win_data        = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and strobe decisions.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A grant needs both a requester and an idle channel.
        if (win_found && cdc_src_ready) begin
          grant   = 1'b1;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        // Ready staying high means the channel has not yet registered the
        // strobe; keep waiting without re-issuing it.
        if (!cdc_src_ready) state_d = INFLIGHT;
      end
      INFLIGHT: begin
        if (cdc_src_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timeout fires on the cycle the in-flight counter reaches TIMEOUT_CYCLES.
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      req_ready     <= '0;
      cdc_src_valid <= 1'b0;
      cdc_src_data  <= '0;
      xfer_done     <= 1'b0;
      grant_id      <= '0;
      busy          <= 1'b0;
      rr_ptr        <= '0;
      tmo_cnt       <= '0;
      err_timeout   <= 1'b0;
    end else begin
      req_ready     <= grant ? win_onehot : '0;
      cdc_src_valid <= grant;
      xfer_done     <= done_d;
      busy          <= (state_d != IDLE);

      if (grant) begin
        cdc_src_data <= win_data;
        grant_id     <= win_id;
        rr_ptr       <= win_next_ptr;
      end

      if (grant) begin
        tmo_cnt <= '0;
      end else if ((state_q != IDLE) && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (tmo_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

`ifdef CDC_XFER_ARB_STATS_EN
  // Counts alongside xfer_done so the value updates in the same cycle the
  // completion pulse is visible.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      xfer_count <= '0;
    end else if (err_clr) begin
      xfer_count <= '0;
    end else if (done_d) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_xfer_arbiter
//
// Self-checking bench for cdc_xfer_arbiter (NUM_REQ=4, DATA_WIDTH=32,
// TIMEOUT_CYCLES=16). A reference model samples inputs on each rising edge
// and queues expected grants and completions; a monitor on the falling edge
// compares DUT outputs against those queues. A channel model emulates the
// handshake synchronizer's ready behaviour. Directed sequences cover reset,
// single request, fairness, channel busy, timeout, reset mid-transfer and the
// optional statistics counter; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_cdc_xfer_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic              dst_clk = 1'b0;
  logic              dst_rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     cdc_src_data;
  logic              cdc_src_valid;
  logic              cdc_src_ready;
  logic              xfer_done;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              err_timeout;
  logic              err_clr;
`ifdef CDC_XFER_ARB_STATS_EN
  logic [31:0]       xfer_count;
`endif

  cdc_xfer_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cdc_src_data(cdc_src_data), .cdc_src_valid(cdc_src_valid),
    .cdc_src_ready(cdc_src_ready), .xfer_done(xfer_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .err_clr(err_clr)
`ifdef CDC_XFER_ARB_STATS_EN
    , .xfer_count(xfer_count)
`endif
  );

  always #5 dst_clk = ~dst_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transfer at a time; winner by modulo scan from the
  // rotation pointer; completion when the channel's ready has dropped and
  // risen again.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    int          id;
    logic [DW-1:0] data;
  } gexp_t;

  gexp_t gq[$];
  int    dq[$];
  int    cyc = 0;
  int    m_rr = 0;
  int    m_phase = 0;  // 0: channel free, 1: awaiting ready drop, 2: awaiting ready rise

  always @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      gq.delete();
      dq.delete();
      m_rr    = 0;
      m_phase = 0;
    end else begin
      cyc++;
      if (m_phase == 0) begin
        if ((req_valid != 0) && cdc_src_ready) begin
          int w;
          w = -1;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
          end
          gq.push_back('{cyc, w, req_data[w*DW +: DW]});
          m_rr    = (w + 1) % N;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!cdc_src_ready) m_phase = 2;
      end else begin
        if (cdc_src_ready) begin
          dq.push_back(cyc);
          m_phase = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares outputs on the falling edge.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] last_data = '0;

  always @(negedge dst_clk) begin
    if (!dst_rst_n) begin
      last_data = '0;
    end else begin
      if (req_ready != 0 || cdc_src_valid) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", {req_ready, cdc_src_valid}, 0);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          check("grant_cycle", cyc, e.cyc);
          check("req_ready", req_ready, (1 << e.id));
          check("src_valid", cdc_src_valid, 1);
          check("grant_id", grant_id, e.id);
          check("src_data", cdc_src_data, e.data);
          last_data = e.data;
        end
      end else begin
        if (gq.size() != 0 && gq[0].cyc < cyc) begin
          check("grant_missing_cycle", cyc, gq[0].cyc);
          void'(gq.pop_front());
        end
        check("data_hold", cdc_src_data, last_data);
      end
      if (xfer_done) begin
        if (dq.size() == 0) check("unexpected_done", xfer_done, 0);
        else check("done_cycle", cyc, dq.pop_front());
      end else if (dq.size() != 0 && dq[0] < cyc) begin
        check("done_missing_cycle", cyc, dq[0]);
        void'(dq.pop_front());
      end
      check("busy", busy, (m_phase != 0));
    end
  end

  // ---------------------------------------------------------------------------
  // Channel model: when enabled, on seeing a strobe it drops ready after a
  // 0-1 cycle lag, keeps it low 1-6 cycles, then raises it.
  // ---------------------------------------------------------------------------
  bit chan_auto = 0;

  initial begin
    forever begin
      @(negedge dst_clk);
      if (chan_auto && dst_rst_n && cdc_src_valid) begin
        int lag, dly;
        lag = $urandom_range(0, 1);
        dly = $urandom_range(1, 6);
        repeat (lag) @(negedge dst_clk);
        cdc_src_ready = 1'b0;
        repeat (dly) @(negedge dst_clk);
        cdc_src_ready = 1'b1;
      end
    end
  end

  task automatic do_reset(input logic ready_at_reset);
    @(negedge dst_clk);
    dst_rst_n     = 1'b0;
    req_valid     = '0;
    err_clr       = 1'b0;
    cdc_src_ready = ready_at_reset;
    repeat (2) @(negedge dst_clk);
    dst_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 100 && !cdc_src_valid; k++) @(negedge dst_clk);
    check(name, cdc_src_valid, 1);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 100 && !xfer_done; k++) @(negedge dst_clk);
    check(name, xfer_done, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && (busy || !cdc_src_ready); k++) @(negedge dst_clk);
    check(name, busy, 0);
  endtask

  // Run n single-requester transfers through the automatic channel model.
  task automatic run_transfers(input int n);
    chan_auto = 1;
    for (int t = 0; t < n; t++) begin
      int r;
      r = $urandom_range(0, N - 1);
      req_data[r*DW +: DW] = $urandom;
      req_valid = '0;
      req_valid[r] = 1'b1;
      wait_valid("xfer_valid");
      req_valid = '0;
      wait_done("xfer_done");
      wait_idle("xfer_idle");
    end
    chan_auto = 0;
  endtask

  initial begin
    int ids[$];

    req_valid     = '0;
    req_data      = '0;
    cdc_src_ready = 1'b1;
    err_clr       = 1'b0;

    // Reset state.
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_valid", cdc_src_valid, 0);
    check("rst_data", cdc_src_data, 0);
    check("rst_done", xfer_done, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    repeat (3) @(negedge dst_clk);
    dst_rst_n = 1'b1;

    // Single request, channel returns ready six cycles after the strobe.
    @(negedge dst_clk);
    req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    wait_valid("single_valid");
    check("single_ready", req_ready, 4'b0100);
    check("single_data", cdc_src_data, 32'hDEAD_BEEF);
    check("single_gid", grant_id, 2);
    req_valid     = '0;
    cdc_src_ready = 1'b0;
    repeat (6) @(negedge dst_clk);
    check("single_valid_once", cdc_src_valid, 0);
    cdc_src_ready = 1'b1;
    @(negedge dst_clk);
    check("single_done", xfer_done, 1);
    check("single_idle", busy, 0);
    @(negedge dst_clk);
    check("single_done_pulse", xfer_done, 0);

    // Fairness from reset with all requesters held.
    do_reset(1'b1);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    req_valid = 4'b1111;
    chan_auto = 1;
    for (int k = 0; k < 400 && ids.size() < 8; k++) begin
      @(negedge dst_clk);
      if (req_ready != 0) ids.push_back(int'(grant_id));
    end
    req_valid = '0;
    check("fair_count", ids.size(), 8);
    foreach (ids[i]) check("fair_order", ids[i], i % N);
    wait_idle("fair_drain");
    chan_auto = 0;

    // Channel busy out of reset: no grant until ready rises.
    do_reset(1'b0);
    req_valid = 4'b0001;
    begin
      bit seen;
      seen = 0;
      repeat (5) begin
        @(negedge dst_clk);
        if (req_ready != 0 || cdc_src_valid) seen = 1;
      end
      check("chbusy_no_grant", seen, 0);
    end
    cdc_src_ready = 1'b1;
    @(negedge dst_clk);
    check("chbusy_grant", req_ready, 4'b0001);
    check("chbusy_valid", cdc_src_valid, 1);
    req_valid     = '0;
    cdc_src_ready = 1'b0;
    repeat (3) @(negedge dst_clk);
    cdc_src_ready = 1'b1;
    wait_done("chbusy_done");
    wait_idle("chbusy_idle");

    // Timeout: channel holds ready low after accepting the strobe.
    req_valid = 4'b0001;
    wait_valid("tmo_valid");
    req_valid     = '0;
    cdc_src_ready = 1'b0;
    repeat (TMO - 1) @(negedge dst_clk);
    check("tmo_not_yet", err_timeout, 0);
    @(negedge dst_clk);
    check("tmo_set", err_timeout, 1);
    repeat (5) @(negedge dst_clk);
    check("tmo_sticky", err_timeout, 1);
    err_clr = 1'b1;
    @(negedge dst_clk);
    err_clr = 1'b0;
    check("tmo_cleared", err_timeout, 0);
    repeat (3) @(negedge dst_clk);
    check("tmo_stay_clear", err_timeout, 0);
    check("tmo_still_busy", busy, 1);
    cdc_src_ready = 1'b1;
    @(negedge dst_clk);
    check("tmo_late_done", xfer_done, 1);

`ifdef CDC_XFER_ARB_STATS_EN
    err_clr = 1'b1;
    @(negedge dst_clk);
    err_clr = 1'b0;
    check("stats_clear0", xfer_count, 0);
    run_transfers(5);
    check("stats_five", xfer_count, 5);
    err_clr = 1'b1;
    @(negedge dst_clk);
    err_clr = 1'b0;
    check("stats_clear", xfer_count, 0);
`else
    run_transfers(5);
`endif

    // Reset in the middle of a transfer.
    req_data[1*DW +: DW] = $urandom | 32'h1;
    req_valid = 4'b0010;
    wait_valid("mid_valid");
    req_valid     = '0;
    cdc_src_ready = 1'b0;
    repeat (3) @(negedge dst_clk);
    check("mid_inflight", busy, 1);
    dst_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", cdc_src_valid, 0);
    check("mid_rst_data", cdc_src_data, 0);
    check("mid_rst_gid", grant_id, 0);
    check("mid_rst_done", xfer_done, 0);
    @(negedge dst_clk);
    dst_rst_n     = 1'b1;
    cdc_src_ready = 1'b1;
    req_data[3*DW +: DW] = $urandom;
    req_valid = 4'b1000;
    @(negedge dst_clk);
    check("mid_regrant", req_ready, 4'b1000);
    check("mid_regrant_gid", grant_id, 3);
    req_valid     = '0;
    cdc_src_ready = 1'b0;
    repeat (2) @(negedge dst_clk);
    cdc_src_ready = 1'b1;
    wait_done("mid_done");
    wait_idle("mid_idle");

    // Randomized traffic against the reference model.
    chan_auto = 1;
    repeat (600) begin
      @(negedge dst_clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (!req_valid[i]) req_data[i*DW +: DW] = $urandom;
          req_valid[i] = ~req_valid[i];
        end
      end
    end
    req_valid = '0;
    wait_idle("rand_drain");
    repeat (2) @(negedge dst_clk);
    check("rand_grants_drained", gq.size(), 0);
    check("rand_dones_drained", dq.size(), 0);
    check("rand_no_timeout", err_timeout, 0);
    chan_auto = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdc_xfer_arbiter.md
Name: cdc_xfer_arbiter

Overview:
- Round-robin arbiter in the dst_clk domain that shares one handshake-type CDC channel among NUM_REQ local requesters.
- The shared channel is a handshake synchronizer instance whose source side is clocked by dst_clk; this block drives that source port and observes its ready.
- Serialises transfers: captures the winner's word, issues a single-cycle valid, tracks the four-phase completion, then re-arbitrates.
- Also provides completion, timeout-error and occupancy status.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, width of each transfer word.
- TIMEOUT_CYCLES, 1024, dst_clk cycles a transfer may stay in flight before err_timeout sets (must be ≥ 8).

Ports:
- dst_clk  input  1  block clock.
- dst_rst_n  input  1  reset: asynchronous, active-low, clock dst_clk.
- req_valid  input  NUM_REQ  per-requester transfer request, level.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: the requester's word was captured.
- cdc_src_data  output  DATA_WIDTH  word to the CDC channel source port.
- cdc_src_valid  output  1  one-cycle issue strobe to the CDC channel.
- cdc_src_ready  input  1  CDC channel idle indication.
- xfer_done  output  1  one-cycle pulse when the in-flight transfer completes.
- grant_id  output  $clog2(NUM_REQ)  index of the last granted requester.
- busy  output  1  high while not in IDLE.
- err_timeout  output  1  sticky timeout flag.
- err_clr  input  1  synchronous clear of err_timeout.

Behaviour:
- Reset values: req_ready=0, cdc_src_valid=0, cdc_src_data=0, xfer_done=0, grant_id=0, busy=0, err_timeout=0, rr_ptr=0, timeout counter=0, state=IDLE.
- All outputs are registered.
- States: IDLE, ACCEPT, INFLIGHT.
- IDLE:
  - Transition condition: |req_valid && cdc_src_ready.
  - Winner = first asserted index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Next cycle: cdc_src_data=req_data[winner], cdc_src_valid=1 for exactly one cycle, req_ready[winner]=1 for exactly one cycle, grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, state→ACCEPT.
  - If cdc_src_ready=0, no grant is made and state stays IDLE.
- ACCEPT:
  - cdc_src_valid=0.
  - If cdc_src_ready=0: state→INFLIGHT.
  - If cdc_src_ready=1: stay in ACCEPT (channel is still registering the strobe); valid is never re-issued.
- INFLIGHT: on cdc_src_ready=1, pulse xfer_done next cycle and go to IDLE.
- Latency:
  - Request sampled at edge N → req_ready and cdc_src_valid high in cycle N+1.
  - Earliest next grant is the cycle after xfer_done.
- cdc_src_data holds the captured word until the next grant, so it stays stable throughout the transfer.
- Timeout:
  - Counter resets on entering ACCEPT and increments each cycle in ACCEPT or INFLIGHT, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets err_timeout.
  - The transfer is not aborted; the FSM keeps waiting.
- err_clr clears err_timeout. If err_clr and a set condition occur in the same cycle, set wins.
- A requester dropping req_valid before being granted is legal and simply loses eligibility. Requesters must hold req_data stable while req_valid is high.
- req_valid for the granted requester is ignored after capture; that requester re-requests by holding valid, and it is served again only after the rotation.
- busy = (state != IDLE).
- Reset mid-transfer: all state returns to reset values immediately. The CDC channel is reset by the same reset domain wiring, owned at system level.

Optional Feature:
- Macro: CDC_XFER_ARB_STATS_EN.
- When defined, adds an output xfer_count (32 bits) that increments on each xfer_done and wraps 0xFFFFFFFF→0. It resets to 0 and is also cleared by err_clr.
- When not defined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid=4'b0100, data[2]=0xDEADBEEF, channel model returns ready after 6 cycles → req_ready=4'b0100 one cycle, cdc_src_data=0xDEADBEEF with one-cycle valid, xfer_done one cycle after ready returns, grant_id=2.
- Fairness: req_valid=4'b1111 held for 8 transfers from reset → grant order 0,1,2,3,0,1,2,3; no requester granted twice before others.
- Channel busy: cdc_src_ready=0 at reset with req_valid=4'b0001 → no req_ready or cdc_src_valid until ready rises; grant occurs the cycle after.
- Timeout: TIMEOUT_CYCLES=16, channel never returns ready after accept → err_timeout=1 at cycle 16 of the transfer and stays set. err_clr pulse clears it. Late ready then produces xfer_done.
- Reset mid-transfer: assert dst_rst_n low while in INFLIGHT → all outputs 0, busy=0, rr_ptr=0; after release, req_valid=4'b1000 grants 3 normally.
- With CDC_XFER_ARB_STATS_EN: 5 completed transfers → xfer_count=5; err_clr → xfer_count=0.
